bullet_launcher: RTL and testbench
==================================

Name: bullet_launcher

Overview:
Consumes the turret-angle stage outputs (initial_b_l_pos_x/y offset, b_override_motion_x/y velocity) and owns the lifetime of the left turret's single projectile. On a fire keypress it spawns the bullet at turret origin plus angle offset and advances it once per clk2 tick. It retires the bullet on hit, screen exit or lifetime expiry, and drives position and status to the sprite renderer and the collision logic.

Parameters:
FIRE_KEY, 8'h2C, keycode that fires (space)
SCREEN_W, 640, x bound (exclusive)
SCREEN_H, 480, y bound (exclusive)
MAX_LIFE, 1023, max FLY ticks before forced retire
EXPLODE_TICKS, 16, ticks explode_active is held
COOLDOWN_TICKS, 30, IDLE ticks after retire before the next shot is accepted

Ports:
clk2  in  1  block clock; one tick = one bullet motion step
Reset  in  1  synchronous, active-low
keycode  in  8  current keyboard code
turret_pos_x  in  10  turret sprite origin x
turret_pos_y  in  10  turret sprite origin y
initial_b_l_pos_x  in  10  spawn offset x from angle stage
initial_b_l_pos_y  in  10  spawn offset y from angle stage
b_override_motion_x  in  10  velocity x per tick, two's complement (10'h3FF = -1)
b_override_motion_y  in  10  velocity y per tick, two's complement
hit  in  1  collision detected this tick
b_l_pos_x  out  10  bullet position x
b_l_pos_y  out  10  bullet position y
bullet_active  out  1  bullet in flight (draw enable)
explode_active  out  1  explosion sprite enable
fire_ack  out  1  one-tick pulse on accepted shot
shots_fired  out  8  accepted-shot count, wraps 255->0

Behaviour:
- Reset (Reset==0 at a clk2 edge) has priority over everything, including mid-flight or mid-explosion. Registers clear to: state IDLE, all outputs 0, key_prev 0, cooldown 0, life counter 0, explode counter 0. No launch occurs on the edge where Reset is released.
- All outputs are registered.
- key_prev registers keycode every tick. fire_req = (keycode==FIRE_KEY) && (key_prev!=FIRE_KEY). A held key fires exactly once.
- States: IDLE, FLY, EXPLODE.
- IDLE:
  - cooldown decrements while >0.
  - On fire_req && cooldown==0: pos <= turret_pos + initial offset (10-bit, modulo 1024); vel latched from b_override_motion; life <= 0; fire_ack=1 for this one tick; shots_fired++; bullet_active=1; next state FLY.
  - Velocity is latched at launch. Angle changes during flight do not affect the bullet.
- FLY (per tick, in priority order):
  - 1. hit=1 -> EXPLODE. pos frozen, bullet_active=0, explode_active=1, explode counter loaded with EXPLODE_TICKS-1.
  - 2. Next pos (pos+vel, mod 1024) has x>=SCREEN_W or y>=SCREEN_H (unsigned compare, so negative wrap counts as out of bounds) -> IDLE. bullet_active=0, cooldown<=COOLDOWN_TICKS, pos holds last in-bounds value.
  - 3. life==MAX_LIFE-1 -> IDLE, same as case 2. This covers vel=(0,0).
  - 4. Otherwise pos<=pos+vel, life++.
  - fire_req is ignored in FLY.
- EXPLODE: counter decrements each tick. At 0 -> IDLE, explode_active=0, cooldown<=COOLDOWN_TICKS. hit and fire_req are ignored.
- hit in IDLE is ignored.
- Spawn positions that are already out of bounds still launch and retire on the first FLY tick.

Decomposition:
- Shared package game_pkg: state enum (IDLE/FLY/EXPLODE), FIRE_KEY, SCREEN_W, SCREEN_H, and a 10-bit position typedef also used by the angle stage and the renderer.
- One natural sub-module, key_edge_detect (keycode register plus match-on-rising-edge). It is reused for the angle keys.

Test Plan:
- turret=(100,200), offset=(85,40), motion=(1,0); press FIRE_KEY for one tick -> next tick fire_ack=1, pos=(185,240), bullet_active=1, shots_fired=1; 10 ticks later pos=(195,240).
- Hold FIRE_KEY for 200 ticks with motion=(1,0) from x=185 -> exactly one fire_ack. Bullet retires when next x would reach 640 (last pos x=639), then cooldown=30.
- Spawn y=2, motion=(0,10'h3FF) -> y=1, y=0, then retire (next y=1023); bullet_active=0 with pos y=0.
- hit=1 on the same tick the next pos goes out of bounds -> EXPLODE wins; explode_active high for exactly 16 ticks, then IDLE.
- Press fire at 5 ticks into cooldown -> no fire_ack. Press again after cooldown==0 -> accepted, shots_fired increments. From 255, the count wraps to 0.
- Reset=0 mid-FLY -> next edge all outputs 0, state IDLE. motion=(0,0) shot -> retires after exactly MAX_LIFE ticks.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants and types used by the turret, angle, bullet and renderer stages.
// Positions are 10-bit screen coordinates that wrap modulo 1024.
package game_pkg;

    typedef logic [9:0] pos_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FLY     = 2'd1;
    localparam logic [1:0] ST_EXPLODE = 2'd2;

    localparam logic [7:0] FIRE_KEY = 8'h2C;
    localparam int         SCREEN_W = 640;
    localparam int         SCREEN_H = 480;

    // Unsigned compare, so a coordinate that wrapped below zero reads as off-screen.
    function automatic logic on_screen(input pos_t x, input pos_t y);
        return (x < 10'(SCREEN_W)) && (y < 10'(SCREEN_H));
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Registers the keycode each tick and flags the first tick a given key appears.
// A held key therefore produces a single match.
module key_edge_detect #(
    parameter logic [7:0] KEY = 8'h2C
) (
    input  logic       clk2,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       match
);

    logic [7:0] key_prev;

    always_ff @(posedge clk2) begin
        if (!Reset) begin
            key_prev <= 8'h00;
        end else begin
            key_prev <= keycode;
        end
    end

    assign match = (keycode == KEY) && (key_prev != KEY);

endmodule

// File: rtl/bullet_launcher.sv
// Owns the left turret's single projectile: spawn on fire, advance one step per tick,
// retire on hit (via explosion), screen exit or lifetime expiry, then enforce a cooldown.
module bullet_launcher
    import game_pkg::*;
#(
    parameter int MAX_LIFE       = 1023,
    parameter int EXPLODE_TICKS  = 16,
    parameter int COOLDOWN_TICKS = 30
) (
    input  logic       clk2,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [9:0] turret_pos_x,
    input  logic [9:0] turret_pos_y,
    input  logic [9:0] initial_b_l_pos_x,
    input  logic [9:0] initial_b_l_pos_y,
    input  logic [9:0] b_override_motion_x,
    input  logic [9:0] b_override_motion_y,
    input  logic       hit,
    output logic [9:0] b_l_pos_x,
    output logic [9:0] b_l_pos_y,
    output logic       bullet_active,
    output logic       explode_active,
    output logic       fire_ack,
    output logic [7:0] shots_fired
);

    localparam int LW = $clog2(MAX_LIFE + 1);
    localparam int EW = $clog2(EXPLODE_TICKS + 1);
    localparam int CW = $clog2(COOLDOWN_TICKS + 1);

    localparam logic [LW-1:0] LIFE_LAST    = LW'(MAX_LIFE - 1);
    localparam logic [EW-1:0] EXPLODE_LOAD = EW'(EXPLODE_TICKS - 1);
    localparam logic [CW-1:0] COOL_LOAD    = CW'(COOLDOWN_TICKS);

    logic [1:0]    state;
    pos_t          vel_x;
    pos_t          vel_y;
    logic [LW-1:0] life;
    logic [EW-1:0] explode_cnt;
    logic [CW-1:0] cooldown;
    logic          fire_req;
    pos_t          next_x;
    pos_t          next_y;

    key_edge_detect #(
        .KEY (FIRE_KEY)
    ) u_fire_key (
        .clk2    (clk2),
        .Reset   (Reset),
        .keycode (keycode),
        .match   (fire_req)
    );

    // Two's-complement velocity added modulo 1024 gives both directions for free.
    assign next_x = b_l_pos_x + vel_x;
    assign next_y = b_l_pos_y + vel_y;

    always_ff @(posedge clk2) begin
        if (!Reset) begin
            state          <= ST_IDLE;
            b_l_pos_x      <= '0;
            b_l_pos_y      <= '0;
            vel_x          <= '0;
            vel_y          <= '0;
            life           <= '0;
            explode_cnt    <= '0;
            cooldown       <= '0;
            bullet_active  <= 1'b0;
            explode_active <= 1'b0;
            fire_ack       <= 1'b0;
            shots_fired    <= '0;
        end else begin
            fire_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fire_req && (cooldown == '0)) begin
                        b_l_pos_x     <= turret_pos_x + initial_b_l_pos_x;
                        b_l_pos_y     <= turret_pos_y + initial_b_l_pos_y;
                        vel_x         <= b_override_motion_x;
                        vel_y         <= b_override_motion_y;
                        life          <= '0;
                        fire_ack      <= 1'b1;
                        shots_fired   <= shots_fired + 8'd1;
                        bullet_active <= 1'b1;
                        state         <= ST_FLY;
                    end else if (cooldown != '0) begin
                        cooldown <= cooldown - 1'b1;
                    end
                end
                ST_FLY: begin
                    if (hit) begin
                        bullet_active  <= 1'b0;
                        explode_active <= 1'b1;
                        explode_cnt    <= EXPLODE_LOAD;
                        state          <= ST_EXPLODE;
                    end else if (!on_screen(next_x, next_y) || (life == LIFE_LAST)) begin
                        // Position holds the last on-screen value for the renderer.
                        bullet_active <= 1'b0;
                        cooldown      <= COOL_LOAD;
                        state         <= ST_IDLE;
                    end else begin
                        b_l_pos_x <= next_x;
                        b_l_pos_y <= next_y;
                        life      <= life + 1'b1;
                    end
                end
                ST_EXPLODE: begin
                    if (explode_cnt == '0) begin
                        explode_active <= 1'b0;
                        cooldown       <= COOL_LOAD;
                        state          <= ST_IDLE;
                    end else begin
                        explode_cnt <= explode_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_launcher.sv
// Directed scenarios for bullet_launcher, checked every cycle against a behavioural model
// and pinned by hand-computed expectations at key points.
module tb_bullet_launcher;

    localparam int LIFE = 1023;

    logic       clk2 = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic [9:0] turret_pos_x, turret_pos_y;
    logic [9:0] initial_b_l_pos_x, initial_b_l_pos_y;
    logic [9:0] b_override_motion_x, b_override_motion_y;
    logic       hit;
    logic [9:0] b_l_pos_x, b_l_pos_y;
    logic       bullet_active, explode_active, fire_ack;
    logic [7:0] shots_fired;

    bullet_launcher dut (
        .clk2                (clk2),
        .Reset               (Reset),
        .keycode             (keycode),
        .turret_pos_x        (turret_pos_x),
        .turret_pos_y        (turret_pos_y),
        .initial_b_l_pos_x   (initial_b_l_pos_x),
        .initial_b_l_pos_y   (initial_b_l_pos_y),
        .b_override_motion_x (b_override_motion_x),
        .b_override_motion_y (b_override_motion_y),
        .hit                 (hit),
        .b_l_pos_x           (b_l_pos_x),
        .b_l_pos_y           (b_l_pos_y),
        .bullet_active       (bullet_active),
        .explode_active      (explode_active),
        .fire_ack            (fire_ack),
        .shots_fired         (shots_fired)
    );

    always #5 clk2 = ~clk2;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Behavioural model: mode is implied by which of the in-flight/boom flags is set.
    int m_x = 0, m_y = 0, m_vx = 0, m_vy = 0, m_age = 0, m_boom = 0, m_cool = 0, m_shots = 0;
    int m_prev = 0;
    bit m_act = 0, m_exp = 0, m_ack = 0, model_on = 0;

    always @(posedge clk2) begin
        int  nx, ny;
        bit  fire;
        if (Reset !== 1'b1) begin
            m_x = 0; m_y = 0; m_vx = 0; m_vy = 0; m_age = 0; m_boom = 0;
            m_cool = 0; m_shots = 0; m_prev = 0;
            m_act = 0; m_exp = 0; m_ack = 0;
            model_on = 1;
        end else begin
            fire   = (int'(keycode) == 'h2C) && (m_prev != 'h2C);
            m_prev = int'(keycode);
            m_ack  = 0;
            if (m_act) begin
                nx = (m_x + m_vx) % 1024;
                ny = (m_y + m_vy) % 1024;
                if (hit) begin
                    m_act = 0; m_exp = 1; m_boom = 16;
                end else if (nx >= 640 || ny >= 480 || m_age + 1 == LIFE) begin
                    m_act = 0; m_cool = 30;
                end else begin
                    m_x = nx; m_y = ny; m_age++;
                end
            end else if (m_exp) begin
                m_boom--;
                if (m_boom == 0) begin
                    m_exp = 0; m_cool = 30;
                end
            end else if (fire && m_cool == 0) begin
                m_x     = (int'(turret_pos_x) + int'(initial_b_l_pos_x)) % 1024;
                m_y     = (int'(turret_pos_y) + int'(initial_b_l_pos_y)) % 1024;
                m_vx    = int'(b_override_motion_x);
                m_vy    = int'(b_override_motion_y);
                m_age   = 0;
                m_act   = 1;
                m_ack   = 1;
                m_shots = (m_shots + 1) % 256;
            end else if (m_cool > 0) begin
                m_cool--;
            end
        end
    end

    always @(negedge clk2) begin
        if (model_on) begin
            chk("cyc_x",     int'(b_l_pos_x),      m_x);
            chk("cyc_y",     int'(b_l_pos_y),      m_y);
            chk("cyc_act",   int'(bullet_active),  int'(m_act));
            chk("cyc_exp",   int'(explode_active), int'(m_exp));
            chk("cyc_ack",   int'(fire_ack),       int'(m_ack));
            chk("cyc_shots", int'(shots_fired),    m_shots);
        end
    end

    task automatic step();
        @(posedge clk2);
        #1;
    endtask

    task automatic press();
        keycode = 8'h2C;
        step();
        keycode = 8'h00;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while ((bullet_active || explode_active) && n < limit) begin
            step();
            n++;
        end
        chk(name, int'(n >= limit), 0);
    endtask

    task automatic set_shot(input int tx, input int ty, input int ox, input int oy,
                            input int vx, input int vy);
        turret_pos_x        = 10'(tx);
        turret_pos_y        = 10'(ty);
        initial_b_l_pos_x   = 10'(ox);
        initial_b_l_pos_y   = 10'(oy);
        b_override_motion_x = 10'(vx);
        b_override_motion_y = 10'(vy);
    endtask

    initial begin
        int acks;
        int cnt;
        Reset   = 1'b0;
        keycode = 8'h00;
        hit     = 1'b0;
        set_shot(100, 200, 85, 40, 1, 0);
        repeat (3) step();
        chk("rst_x", int'(b_l_pos_x), 0);
        chk("rst_act", int'(bullet_active), 0);
        chk("rst_shots", int'(shots_fired), 0);
        Reset = 1'b1;
        step();

        // Basic launch and flight.
        press();
        chk("launch_ack", int'(fire_ack), 1);
        chk("launch_x", int'(b_l_pos_x), 185);
        chk("launch_y", int'(b_l_pos_y), 240);
        chk("launch_act", int'(bullet_active), 1);
        chk("launch_shots", int'(shots_fired), 1);
        repeat (10) step();
        chk("fly10_x", int'(b_l_pos_x), 195);
        chk("fly10_ack", int'(fire_ack), 0);
        wait_idle("exit1_timeout", 600);
        chk("exit1_x", int'(b_l_pos_x), 639);

        // Press during cooldown is rejected.
        repeat (5) step();
        keycode = 8'h2C;
        step();
        chk("cool_ack", int'(fire_ack), 0);
        keycode = 8'h00;
        repeat (30) step();

        // Held key fires exactly once.
        keycode = 8'h2C;
        acks = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (fire_ack) acks++;
        end
        keycode = 8'h00;
        chk("hold_acks", acks, 1);
        chk("hold_shots", int'(shots_fired), 2);
        wait_idle("exit2_timeout", 700);
        chk("exit2_x", int'(b_l_pos_x), 639);
        chk("exit2_act", int'(bullet_active), 0);

        // Negative velocity wraps past y=0 and retires.
        repeat (31) step();
        set_shot(100, 0, 0, 2, 0, 'h3FF);
        press();
        chk("neg_y2", int'(b_l_pos_y), 2);
        step();
        chk("neg_y1", int'(b_l_pos_y), 1);
        step();
        chk("neg_y0", int'(b_l_pos_y), 0);
        step();
        chk("neg_act", int'(bullet_active), 0);
        chk("neg_hold_y", int'(b_l_pos_y), 0);

        // Hit coinciding with screen exit explodes for 16 ticks.
        repeat (31) step();
        press();
        repeat (2) step();
        hit = 1'b1;
        step();
        hit = 1'b0;
        chk("boom_exp", int'(explode_active), 1);
        chk("boom_act", int'(bullet_active), 0);
        chk("boom_y", int'(b_l_pos_y), 0);
        cnt = 1;
        repeat (20) begin
            step();
            if (explode_active) cnt++;
        end
        chk("boom_len", cnt, 16);

        // Reset mid-flight.
        repeat (31) step();
        set_shot(100, 200, 85, 40, 1, 0);
        press();
        repeat (3) step();
        Reset = 1'b0;
        step();
        chk("mrst_x", int'(b_l_pos_x), 0);
        chk("mrst_y", int'(b_l_pos_y), 0);
        chk("mrst_act", int'(bullet_active), 0);
        chk("mrst_shots", int'(shots_fired), 0);
        Reset = 1'b1;
        step();

        // Stationary bullet lives exactly MAX_LIFE ticks.
        set_shot(100, 200, 85, 40, 0, 0);
        press();
        cnt = int'(bullet_active);
        for (int i = 0; i < 1100; i++) begin
            step();
            if (!bullet_active) break;
            cnt++;
        end
        chk("life_len", cnt, 1023);
        chk("life_shots", int'(shots_fired), 1);

        // Off-screen spawns launch and retire at once; drive the counter round.
        repeat (31) step();
        set_shot(100, 200, 600, 40, 1, 0);
        press();
        chk("oob_act", int'(bullet_active), 1);
        chk("oob_x", int'(b_l_pos_x), 700);
        step();
        chk("oob_ret", int'(bullet_active), 0);
        repeat (32) step();
        for (int i = 0; i < 253; i++) begin
            press();
            repeat (33) step();
        end
        chk("wrap_255", int'(shots_fired), 255);
        press();
        chk("wrap_0", int'(shots_fired), 0);
        chk("wrap_ack", int'(fire_ack), 1);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
